// File: rtl/reg_file_pkg.sv
// reg_file_pkg: shared constants and types for the register file / rename table.
// Fallback values for the shared ROB defines are provided here so the slice
// also builds on its own; an earlier definition of the same macros wins.
// Optional feature macro used by this slice: REG_FILE_PERF_EN.
`ifndef ROB_WIDTH
`define ROB_WIDTH 4
`endif
`ifndef ROB_SIZE
`define ROB_SIZE 16
`endif
`ifndef REG_NUM
`define REG_NUM 32
`endif

package reg_file_pkg;
  localparam int XLEN        = 32;
  localparam int REG_ID_W    = 5;
  localparam int ROB_W_DEF   = `ROB_WIDTH;
  localparam int REG_NUM_DEF = `REG_NUM;

  // Where a search port takes its answer from.
  typedef enum logic [1:0] {
    SRC_ZERO   = 2'd0,  // x0
    SRC_BYPASS = 2'd1,  // producer is committing this very cycle
    SRC_ROB    = 2'd2,  // producer still in flight, report its tag
    SRC_ARCH   = 2'd3   // architectural value is current
  } src_kind_t;
endpackage

// File: rtl/reg_file_if.sv
// reg_file_if: decoder issue, ROB commit/flush and search result bundle.
// master = decoder/ROB side, slave = register file.
interface reg_file_if
  import reg_file_pkg::*;
#(
  parameter int ROB_W = ROB_W_DEF
) ();
  logic                clear;
  logic                dec_ready;
  logic                dec_rename;
  logic [REG_ID_W-1:0] dec_rd;
  logic [ROB_W-1:0]    dec_rob_id;
  logic [REG_ID_W-1:0] dec_rs1;
  logic [REG_ID_W-1:0] dec_rs2;
  logic                commit_ready;
  logic [ROB_W-1:0]    commit_rob_id;
  logic [REG_ID_W-1:0] commit_reg_id;
  logic [XLEN-1:0]     commit_val;
  logic                search_has_dep_1;
  logic [ROB_W-1:0]    search_rob_id_1;
  logic [XLEN-1:0]     search_val_1;
  logic                search_has_dep_2;
  logic [ROB_W-1:0]    search_rob_id_2;
  logic [XLEN-1:0]     search_val_2;

  modport master (
    output clear, dec_ready, dec_rename, dec_rd, dec_rob_id, dec_rs1, dec_rs2,
    output commit_ready, commit_rob_id, commit_reg_id, commit_val,
    input  search_has_dep_1, search_rob_id_1, search_val_1,
    input  search_has_dep_2, search_rob_id_2, search_val_2
  );

  modport slave (
    input  clear, dec_ready, dec_rename, dec_rd, dec_rob_id, dec_rs1, dec_rs2,
    input  commit_ready, commit_rob_id, commit_reg_id, commit_val,
    output search_has_dep_1, search_rob_id_1, search_val_1,
    output search_has_dep_2, search_rob_id_2, search_val_2
  );
endinterface

// File: rtl/reg_file.sv
// reg_file: architectural register file plus rename table.
// Two combinational search ports with commit bypass, commit write-back,
// rename on issue and full tag drop on flush. x0 is hard-wired to zero.
// Optional macro REG_FILE_PERF_EN adds commit_cnt / stall_dep_cnt counters.
module reg_file
  import reg_file_pkg::*;
#(
  parameter int REG_NUM = REG_NUM_DEF,
  parameter int ROB_W   = ROB_W_DEF
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             rdy_in,
`ifdef REG_FILE_PERF_EN
  output logic [XLEN-1:0]  commit_cnt,
  output logic [XLEN-1:0]  stall_dep_cnt,
`endif
  reg_file_if.slave        bus
);

  // Read views of per-register state, indexable by register id.
  logic [XLEN-1:0]  w_val_arr [REG_NUM];
  logic             w_dep_arr [REG_NUM];
  logic [ROB_W-1:0] w_tag_arr [REG_NUM];

  logic [REG_ID_W-1:0] w_rs [2];
  assign w_rs[0] = bus.dec_rs1;
  assign w_rs[1] = bus.dec_rs2;

  genvar gi;

  // Per-register storage; x0 has no storage and reads as zero.
  for (gi = 0; gi < REG_NUM; gi++) begin : g_reg
    if (gi == 0) begin : g_zero
      assign w_val_arr[gi] = '0;
      assign w_dep_arr[gi] = 1'b0;
      assign w_tag_arr[gi] = '0;
    end else begin : g_live
      localparam logic [REG_ID_W-1:0] IDX = REG_ID_W'(gi);
      logic [XLEN-1:0]  r_val;
      logic             r_dep;
      logic [ROB_W-1:0] r_tag;
      logic             w_commit_hit;
      logic             w_rename_hit;

      assign w_commit_hit = bus.commit_ready && (bus.commit_reg_id == IDX);
      assign w_rename_hit = bus.dec_ready && bus.dec_rename && (bus.dec_rd == IDX);

      // Value write-back always lands; flush beats rename beats commit-clear.
      always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
          r_val <= '0;
          r_dep <= 1'b0;
          r_tag <= '0;
        end else if (rdy_in) begin
          if (w_commit_hit) begin
            r_val <= bus.commit_val;
          end
          if (bus.clear) begin
            r_dep <= 1'b0;
          end else if (w_rename_hit) begin
            r_dep <= 1'b1;
            r_tag <= bus.dec_rob_id;
          end else if (w_commit_hit && r_dep && (r_tag == bus.commit_rob_id)) begin
            r_dep <= 1'b0;
          end
        end
      end

      assign w_val_arr[gi] = r_val;
      assign w_dep_arr[gi] = r_dep;
      assign w_tag_arr[gi] = r_tag;
    end
  end

  // Search mux, one instance per source port.
  for (gi = 0; gi < 2; gi++) begin : g_search
    src_kind_t        w_kind;
    logic             w_has_dep;
    logic [ROB_W-1:0] w_rob_id;
    logic [XLEN-1:0]  w_val;
    logic             w_dep;
    logic [ROB_W-1:0] w_tag;

    assign w_dep = w_dep_arr[w_rs[gi]];
    assign w_tag = w_tag_arr[w_rs[gi]];

    // Classify where the operand comes from; bypass needed since the ROB
    // releases the committing tag and can no longer resolve it.
    always_comb begin
      w_kind = SRC_ARCH;
      if (w_rs[gi] == '0) begin
        w_kind = SRC_ZERO;
      end else if (w_dep && bus.commit_ready && (w_tag == bus.commit_rob_id)) begin
        w_kind = SRC_BYPASS;
      end else if (w_dep) begin
        w_kind = SRC_ROB;
      end
    end

    // Drive the result fields from the classification.
    always_comb begin
      w_has_dep = 1'b0;
      w_rob_id  = '0;
      w_val     = '0;
      case (w_kind)
        SRC_BYPASS: w_val = bus.commit_val;
        SRC_ROB: begin
          w_has_dep = 1'b1;
          w_rob_id  = w_tag;
        end
        SRC_ARCH:   w_val = w_val_arr[w_rs[gi]];
        default:    w_val = '0;
      endcase
    end

    if (gi == 0) begin : g_port1
      assign bus.search_has_dep_1 = w_has_dep;
      assign bus.search_rob_id_1  = w_rob_id;
      assign bus.search_val_1     = w_val;
    end else begin : g_port2
      assign bus.search_has_dep_2 = w_has_dep;
      assign bus.search_rob_id_2  = w_rob_id;
      assign bus.search_val_2     = w_val;
    end
  end

`ifdef REG_FILE_PERF_EN
  logic [XLEN-1:0] r_commit_cnt;
  logic [XLEN-1:0] r_stall_dep_cnt;

  // Count commits (x0 included) and issue cycles that saw a pending operand.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_commit_cnt    <= '0;
      r_stall_dep_cnt <= '0;
    end else if (rdy_in) begin
      if (bus.commit_ready) begin
        r_commit_cnt <= r_commit_cnt + 1'b1;
      end
      if (bus.dec_ready && (bus.search_has_dep_1 || bus.search_has_dep_2)) begin
        r_stall_dep_cnt <= r_stall_dep_cnt + 1'b1;
      end
    end
  end

  assign commit_cnt    = r_commit_cnt;
  assign stall_dep_cnt = r_stall_dep_cnt;
`endif

endmodule
